lbp_hist: RTL and testbench

LBP_HIST -- requirements
Module: lbp_hist

---
 rtl/lbp_hist_pkg.sv | 14 +
 rtl/lbp_hist_bank.sv | 41 ++++
 rtl/lbp_hist.sv | 99 +++++++++
 tb/tb_lbp_hist.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_hist_pkg.sv
// Shared types and defaults for the LBP histogram block.
package lbp_hist_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NBIN_DEF   = 256;
    localparam int IMG_PIXELS = 16384;
    localparam int CNT_W_DEF  = 15;

endpackage

// File: rtl/lbp_hist_bank.sv
// Bin counter array: saturating increment on one port, read plus clear-on-read on the other.
module lbp_hist_bank
    import lbp_hist_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NBIN  = NBIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [7:0]       inc_idx,
    input  logic             clr_en,
    input  logic [7:0]       rd_idx,
    output logic [CNT_W-1:0] rd_count
);

    logic [CNT_W-1:0] cnt [NBIN];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Increment and clear never coincide: counting happens only while accumulating.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (inc_en) begin
                cnt[inc_idx] <= sat_inc(cnt[inc_idx]);
            end
            if (clr_en) begin
                cnt[rd_idx] <= '0;
            end
        end
    end

    assign rd_count = cnt[rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulate a frame, dump bins 0..NBIN-1 over a valid/ready port, then clear.
module lbp_hist
    import lbp_hist_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NBIN  = NBIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             overrun
);

    localparam logic [7:0] LAST_BIN = 8'(NBIN - 1);

    state_t           state;
    state_t           state_nxt;
    logic             finish_p1;
    logic             finish_armed;
    logic             finish_rise;
    logic             accept;
    logic [CNT_W-1:0] bank_count;
    logic             unused_addr;

    assign unused_addr = ^lbp_addr;

    // finish_armed stays low after reset until finish has been seen low,
    // so a level left high across reset cannot start a dump.
    assign finish_rise = finish & ~finish_p1 & finish_armed;
    assign accept      = (state == DUMP) & hist_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            finish_p1    <= 1'b0;
            finish_armed <= 1'b0;
            hist_bin     <= 8'd0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            finish_p1    <= finish;
            finish_armed <= finish_armed | ~finish;
            if (lbp_valid && (state != ACCUM)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                hist_bin <= (hist_bin == LAST_BIN) ? 8'd0 : hist_bin + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        hist_valid = 1'b0;
        hist_done  = 1'b0;
        unique case (state)
            ACCUM: begin
                if (finish_rise) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                hist_valid = 1'b1;
                if (accept && (hist_bin == LAST_BIN)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                hist_done = 1'b1;
                state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign hist_count = hist_valid ? bank_count : '0;

    lbp_hist_bank #(
        .CNT_W (CNT_W),
        .NBIN  (NBIN)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (lbp_valid && (state == ACCUM)),
        .inc_idx  (lbp_data),
        .clr_en   (accept),
        .rd_idx   (hist_bin),
        .rd_count (bank_count)
    );

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: full-width and CNT_W=4 instances driven by the same stimulus.
module tb_lbp_hist;
    import lbp_hist_pkg::*;

    typedef struct {
        logic [7:0] code;
        int         n;
        int         exp_full;
        int         exp_sat;
    } frame_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_ready;
    logic        hist_valid, hist_done, overrun;
    logic [7:0]  hist_bin;
    logic [14:0] hist_count;
    logic        hist_valid4, hist_done4, overrun4;
    logic [7:0]  hist_bin4;
    logic [3:0]  hist_count4;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_h  [256];
    int got_h  [256];
    int got4_h [256];

    always @(posedge clk) cyc <= cyc + 1;

    lbp_hist #(.CNT_W(15), .NBIN(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done),
        .overrun    (overrun)
    );

    lbp_hist #(.CNT_W(4), .NBIN(256)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid4),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin4),
        .hist_count (hist_count4),
        .hist_done  (hist_done4),
        .overrun    (overrun4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) exp_h[i] = 0;
    endtask

    task automatic send(input logic [7:0] code);
        lbp_valid = 1'b1;
        lbp_data  = code;
        lbp_addr  = lbp_addr + 14'd1;
        exp_h[code]++;
        tick();
        lbp_valid = 1'b0;
    endtask

    // Raise finish (optionally with a sample on the edge cycle), collect all bins,
    // then check the DONE pulse.
    task automatic dump(input bit stall, input bit edge_smp, input logic [7:0] edge_code,
                        input bit inject);
        int b, k, c0, ord_bad, stab_bad;
        bit pstall;
        logic [7:0]  pbin;
        logic [14:0] pcnt;
        if (finish) begin
            finish = 1'b0;
            tick();
        end
        finish     = 1'b1;
        hist_ready = 1'b1;
        if (edge_smp) begin
            lbp_valid = 1'b1;
            lbp_data  = edge_code;
            exp_h[edge_code]++;
        end
        c0 = cyc;
        tick();
        lbp_valid = inject;
        lbp_data  = edge_code;
        b = 0; k = 0; ord_bad = 0; stab_bad = 0; pstall = 1'b0; pbin = 8'd0; pcnt = 15'd0;
        while (b < 256 && k < 4000) begin
            hist_ready = stall ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            if (hist_valid === 1'b1) begin
                if (pstall && (hist_bin !== pbin || hist_count !== pcnt)) stab_bad++;
                if (hist_ready) begin
                    if (hist_bin !== 8'(b)) ord_bad++;
                    got_h[b]  = int'(hist_count);
                    got4_h[b] = int'(hist_count4);
                    b++;
                end
                pstall = !hist_ready;
                pbin   = hist_bin;
                pcnt   = hist_count;
            end else begin
                ord_bad++;
            end
            if (hist_done !== 1'b0) ord_bad++;
            tick();
            lbp_valid = 1'b0;
            k++;
        end
        check("dump bins accepted", b, 256);
        check("dump order/valid", ord_bad, 0);
        if (stall) check("stall stability", stab_bad, 0);
        check("hist_done pulse", hist_done, 1'b1);
        check("valid low in DONE", hist_valid, 1'b0);
        if (!stall) check("done latency", cyc - c0, 257);
        hist_ready = 1'b0;
        tick();
        check("hist_done one cycle", hist_done, 1'b0);
        finish = 1'b0;
    endtask

    task automatic compare_bins(input string tag);
        int sum_got, sum_exp;
        sum_got = 0;
        sum_exp = 0;
        for (int i = 0; i < 256; i++) begin
            check($sformatf("%s bin %0d", tag, i), got_h[i], exp_h[i]);
            sum_got += got_h[i];
            sum_exp += exp_h[i];
        end
        check({tag, " sum"}, sum_got, sum_exp);
        clear_model();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_rec_t tbl [5];
        bit done_seen;
        int k;
        tbl[0] = '{8'h03, 20, 20, 15};
        tbl[1] = '{8'hff,  1,  1,  1};
        tbl[2] = '{8'h80, 15, 15, 15};
        tbl[3] = '{8'h81, 16, 16, 15};
        tbl[4] = '{8'h10,  3,  3,  3};

        reset = 1'b1; lbp_valid = 1'b0; lbp_addr = 14'd0; lbp_data = 8'd0;
        finish = 1'b0; hist_ready = 1'b0;
        clear_model();
        tick();
        tick();
        check("reset hist_valid", hist_valid, 1'b0);
        check("reset hist_bin",   hist_bin,   8'd0);
        check("reset hist_count", hist_count, 15'd0);
        check("reset hist_done",  hist_done,  1'b0);
        check("reset overrun",    overrun,    1'b0);
        reset = 1'b0;
        tick();

        // Scenario 1: a full frame of code 0.
        for (int i = 0; i < 16384; i++) send(8'h00);
        dump(1'b0, 1'b0, 8'h00, 1'b0);
        compare_bins("s1");
        check("overrun still clear", overrun, 1'b0);

        // Scenarios 2/3: every code 64 times in back-to-back pairs, dumped with stalls.
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 256; c++) begin
                send(8'(c));
                send(8'(c));
            end
        end
        dump(1'b1, 1'b0, 8'h00, 1'b0);
        compare_bins("s2");

        // Scenario 4: sample on the finish edge counts, sample in DUMP does not.
        send(8'h05); send(8'h05); send(8'h05); send(8'h20);
        dump(1'b0, 1'b1, 8'h05, 1'b1);
        compare_bins("s4");
        check("overrun sticky", overrun, 1'b1);

        // Scenario 5: reset at bin 100 with finish held high across reset.
        send(8'h64); send(8'h64); send(8'h01);
        finish     = 1'b1;
        hist_ready = 1'b1;
        tick();
        k = 0;
        while (!(hist_valid === 1'b1 && hist_bin === 8'd100) && k < 1000) begin
            tick();
            k++;
        end
        check("reached bin 100", hist_bin, 8'd100);
        reset = 1'b1;
        tick();
        check("abort hist_valid", hist_valid, 1'b0);
        check("abort hist_bin",   hist_bin,   8'd0);
        check("abort hist_count", hist_count, 15'd0);
        check("abort overrun",    overrun,    1'b0);
        reset = 1'b0;
        hist_ready = 1'b0;
        clear_model();
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(8'h07);
            if (hist_valid !== 1'b0 || hist_done !== 1'b0) done_seen = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (hist_valid !== 1'b0 || hist_done !== 1'b0) done_seen = 1'b1;
        end
        check("no dump after abort", done_seen, 1'b0);
        dump(1'b0, 1'b0, 8'h00, 1'b0);
        compare_bins("s5");

        // Scenario 6: table frame, checked on both widths.
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < tbl[t].n; j++) send(tbl[t].code);
        end
        dump(1'b0, 1'b0, 8'h00, 1'b0);
        for (int t = 0; t < 5; t++) begin
            check($sformatf("tbl %0d full", t), got_h[tbl[t].code], tbl[t].exp_full);
            check($sformatf("tbl %0d sat4", t), got4_h[tbl[t].code], tbl[t].exp_sat);
        end
        compare_bins("s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
